// File: rtl/aes_test_pkg.sv
// aes_test_pkg: shared state encoding and 16-byte test pattern for the link transmitter
package aes_test_pkg;
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, GAP} tx_state_t;
    localparam int PATTERN_LEN = 16;
    localparam logic [7:0] TEST_PATTERN [0:PATTERN_LEN-1] = '{
        8'haa, 8'h00, 8'h24, 8'hfd, 8'hd8, 8'h91, 8'he2, 8'h28,
        8'h67, 8'h78, 8'h01, 8'hfe, 8'h62, 8'h04, 8'h8c, 8'hcf
    };
endpackage

// File: rtl/test_pattern_rom.sv
// test_pattern_rom: combinational lookup of the fixed test pattern
module test_pattern_rom
    import aes_test_pkg::*;
(
    input  logic [3:0] addr,
    output logic [7:0] data
);
    always_comb begin
        case (addr)
            4'd0:  data = TEST_PATTERN[0];
            4'd1:  data = TEST_PATTERN[1];
            4'd2:  data = TEST_PATTERN[2];
            4'd3:  data = TEST_PATTERN[3];
            4'd4:  data = TEST_PATTERN[4];
            4'd5:  data = TEST_PATTERN[5];
            4'd6:  data = TEST_PATTERN[6];
            4'd7:  data = TEST_PATTERN[7];
            4'd8:  data = TEST_PATTERN[8];
            4'd9:  data = TEST_PATTERN[9];
            4'd10: data = TEST_PATTERN[10];
            4'd11: data = TEST_PATTERN[11];
            4'd12: data = TEST_PATTERN[12];
            4'd13: data = TEST_PATTERN[13];
            4'd14: data = TEST_PATTERN[14];
            4'd15: data = TEST_PATTERN[15];
        endcase
    end
endmodule

// File: rtl/test_transmitter.sv
// test_transmitter: strobe-on-falling-edge byte source repeating the test pattern NUM_BLOCKS times
module test_transmitter
    import aes_test_pkg::*;
#(
    parameter int SETUP_CYC  = 4,
    parameter int HIGH_CYC   = 8,
    parameter int HOLD_CYC   = 4,
    parameter int BLOCK_GAP  = 16,
    parameter int NUM_BLOCKS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       ready,
    output logic       write_en,
    output logic [7:0] write_data,
    output logic       busy,
    output logic       done,
    output logic [7:0] byte_cnt
);
    localparam int M1   = SETUP_CYC > HIGH_CYC ? SETUP_CYC : HIGH_CYC;
    localparam int M2   = HOLD_CYC > BLOCK_GAP ? HOLD_CYC : BLOCK_GAP;
    localparam int MAXC = M1 > M2 ? M1 : M2;
    localparam int PW   = MAXC > 1 ? $clog2(MAXC) : 1;
    localparam logic [PW-1:0] SETUP_END = PW'(SETUP_CYC - 1);
    localparam logic [PW-1:0] HIGH_END  = PW'(HIGH_CYC - 1);
    localparam logic [PW-1:0] HOLD_END  = PW'(HOLD_CYC - 1);
    localparam logic [PW-1:0] GAP_END   = PW'(BLOCK_GAP - 1);
    localparam logic [3:0]    LAST_IDX  = 4'(PATTERN_LEN - 1);
    localparam logic [3:0]    LAST_BLK  = 4'(NUM_BLOCKS - 1);

    tx_state_t     state, state_d;
    logic [PW-1:0] phase, phase_d;
    logic [3:0]    idx, idx_d, blk, blk_d, rom_addr;
    logic [7:0]    rom_byte, wd_d, cnt_d;
    logic          we_d, busy_d, done_d;

    // the only loads are the next in-block byte from HOLD, otherwise byte 0
    assign rom_addr = (state == HOLD && idx != LAST_IDX) ? idx + 4'd1 : 4'd0;

    test_pattern_rom u_rom (.addr(rom_addr), .data(rom_byte));

    always_comb begin
        state_d = state;
        phase_d = phase;
        idx_d   = idx;
        blk_d   = blk;
        we_d    = write_en;
        wd_d    = write_data;
        busy_d  = busy;
        done_d  = done;
        cnt_d   = byte_cnt;
        case (state)
            IDLE: if (start) begin
                wd_d    = rom_byte;
                busy_d  = 1'b1;
                done_d  = 1'b0;
                cnt_d   = 8'd0;
                idx_d   = 4'd0;
                blk_d   = 4'd0;
                phase_d = '0;
                state_d = SETUP;
            end
            // phase saturates at the end of setup so a ready stall just waits
            SETUP: if (phase != SETUP_END) phase_d = phase + PW'(1);
                else if (ready) begin
                    we_d    = 1'b1;
                    phase_d = '0;
                    state_d = STROBE;
                end
            STROBE: if (phase != HIGH_END) phase_d = phase + PW'(1);
                else begin
                    we_d    = 1'b0;
                    cnt_d   = byte_cnt + 8'd1;
                    phase_d = '0;
                    state_d = HOLD;
                end
            HOLD: if (phase != HOLD_END) phase_d = phase + PW'(1);
                else begin
                    phase_d = '0;
                    if (idx != LAST_IDX) begin
                        idx_d   = idx + 4'd1;
                        wd_d    = rom_byte;
                        state_d = SETUP;
                    end else if (blk != LAST_BLK) begin
                        idx_d   = 4'd0;
                        blk_d   = blk + 4'd1;
                        state_d = GAP;
                    end else begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            GAP: if (phase != GAP_END) phase_d = phase + PW'(1);
                else begin
                    wd_d    = rom_byte;
                    phase_d = '0;
                    state_d = SETUP;
                end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            phase      <= '0;
            idx        <= 4'd0;
            blk        <= 4'd0;
            write_en   <= 1'b0;
            write_data <= 8'h00;
            busy       <= 1'b0;
            done       <= 1'b0;
            byte_cnt   <= 8'd0;
        end else begin
            state      <= state_d;
            phase      <= phase_d;
            idx        <= idx_d;
            blk        <= blk_d;
            write_en   <= we_d;
            write_data <= wd_d;
            busy       <= busy_d;
            done       <= done_d;
            byte_cnt   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_test_transmitter.sv
// tb_test_transmitter: sink-model bench with randomized ready and launch spacing
module tb_test_transmitter;
    localparam int SETUP_CYC = 4;
    localparam int HOLD_CYC  = 4;

    logic       clk = 1'b0, rst = 1'b0, start = 1'b0, ready = 1'b1, start1 = 1'b0;
    logic       write_en, busy, done, we1, busy1, done1;
    logic [7:0] write_data, byte_cnt, wd1, cnt1;
    logic [7:0] pat [16] = '{8'haa, 8'h00, 8'h24, 8'hfd, 8'hd8, 8'h91, 8'he2, 8'h28,
                             8'h67, 8'h78, 8'h01, 8'hfe, 8'h62, 8'h04, 8'h8c, 8'hcf};
    logic [7:0] cap [$];
    logic [7:0] cap1 [$];
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    test_transmitter dut (
        .clk(clk), .rst(rst), .start(start), .ready(ready), .write_en(write_en),
        .write_data(write_data), .busy(busy), .done(done), .byte_cnt(byte_cnt)
    );

    test_transmitter #(.NUM_BLOCKS(1), .BLOCK_GAP(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .ready(1'b1), .write_en(we1),
        .write_data(wd1), .busy(busy1), .done(done1), .byte_cnt(cnt1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // sink model: capture on each valid write_en fall and watch data stability
    logic       pwe = 1'b0, pwe1 = 1'b0;
    logic [7:0] last_wd = 8'h00;
    int         stable = 0, hold_w = 0;
    always @(negedge clk) begin
        stable = (write_data == last_wd) ? stable + 1 : 0;
        if (!rst) hold_w = 0;
        else begin
            if (pwe && !write_en) begin
                cap.push_back(write_data);
                hold_w = HOLD_CYC - 1;
            end else if (hold_w > 0) begin
                check("hold_stable", write_data, last_wd);
                hold_w--;
            end
            if (!pwe && write_en) check("setup_stable", stable >= SETUP_CYC, 1);
            if (pwe && write_en) check("high_stable", write_data, last_wd);
        end
        last_wd = write_data;
        pwe = write_en;
        if (rst && pwe1 && !we1) cap1.push_back(wd1);
        pwe1 = we1;
    end

    task automatic check_run(input int n);
        check("n_bytes", cap.size(), n);
        foreach (cap[i]) check("byte", cap[i], pat[i % 16]);
    endtask

    task automatic launch();
        repeat ($urandom_range(1, 5)) @(negedge clk);
        start = 1'b1;
        cap.delete();
        @(negedge clk);
        start = 1'b0;
        check("launch_data", write_data, 8'haa);
        check("launch_busy", busy, 1);
        check("launch_done", done, 0);
        check("launch_cnt", byte_cnt, 0);
    endtask

    task automatic wait_done(input int budget, input bit rnd, output int el);
        el = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (rnd) ready = $urandom_range(0, 3) != 0;
            if (done) begin
                el = i;
                break;
            end
        end
        ready = 1'b1;
        check("done_timeout", el > 0, 1);
    endtask

    task automatic wait_for(input int budget, input int cnt, input bit we, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            ok = byte_cnt == 8'(cnt) && write_en == we && (we || write_data == pat[cnt]);
        end
        check("wait_timeout", ok, 1);
    endtask

    initial begin
        int el;
        bit ok;
        repeat (3) @(negedge clk);
        check("rst_we", write_en, 0);
        check("rst_data", write_data, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cnt", byte_cnt, 0);
        rst = 1'b1;

        launch();
        wait_done(1500, 0, el);
        check("run_cycles", el, 1072);
        check("run_cnt", byte_cnt, 64);
        check("run_busy", busy, 0);
        check_run(64);

        launch();
        wait_done(6000, 1, el);
        check("rnd_cnt", byte_cnt, 64);
        check_run(64);

        launch();
        wait_for(400, 4, 1'b0, ok);
        ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("stall_we", write_en, 0);
            check("stall_data", write_data, 8'hd8);
        end
        ready = 1'b1;
        @(negedge clk);
        check("stall_rise", write_en, 1);
        check("stall_cnt", byte_cnt, 4);
        wait_done(1500, 0, el);
        check("stall_run_cnt", byte_cnt, 64);
        check_run(64);

        launch();
        wait_for(400, 9, 1'b1, ok);
        #3 rst = 1'b0;
        #1;
        check("arst_we", write_en, 0);
        check("arst_data", write_data, 8'h00);
        check("arst_busy", busy, 0);
        check("arst_cnt", byte_cnt, 0);
        repeat (3) @(negedge clk);
        #3 rst = 1'b1;
        launch();
        wait_done(1500, 0, el);
        check("rerun_cycles", el, 1072);
        check_run(64);

        @(negedge clk);
        start = 1'b1;
        cap.delete();
        @(negedge clk);
        wait_done(1500, 0, el);
        check("b2b_first", el, 1072);
        check_run(64);
        cap.delete();
        @(negedge clk);
        check("b2b_done_clr", done, 0);
        check("b2b_cnt_clr", byte_cnt, 0);
        check("b2b_busy", busy, 1);
        check("b2b_data", write_data, 8'haa);
        wait_done(1500, 0, el);
        start = 1'b0;
        check("b2b_second", el, 1072);
        check_run(64);
        @(negedge clk);
        check("b2b_done_sticky", done, 1);

        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        el = -1;
        for (int i = 1; i <= 400 && el < 0; i++) begin
            @(negedge clk);
            if (done1) el = i;
        end
        check("nb1_cycles", el, 256);
        check("nb1_cnt", cnt1, 16);
        check("nb1_n", cap1.size(), 16);
        foreach (cap1[i]) check("nb1_byte", cap1[i], pat[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
